// File: rtl/pmem_arbiter_rr.sv
// Round-robin arbiter granting one cache miss port at a time onto the physical-memory line port.
// Define PMEM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module pmem_arbiter_rr #(
    parameter  int unsigned NUM_PORTS = 2,
    parameter  int unsigned ADDR_W    = 32,
    parameter  int unsigned LINE_W    = 256,
    localparam int unsigned PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req_read,
    input  logic [NUM_PORTS-1:0]        req_write,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*LINE_W-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]        req_resp,
    output logic [LINE_W-1:0]           req_rdata,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [LINE_W-1:0]           mem_wdata,
    input  logic                        mem_resp,
    input  logic [LINE_W-1:0]           mem_rdata,
    output logic [PTR_W-1:0]            grant_id,
    output logic                        busy
);

    localparam logic [PTR_W:0]   NUM_P = (PTR_W+1)'(NUM_PORTS);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(NUM_PORTS - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   grant_q, grant_d;
    logic               mem_read_q, mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]  mem_wdata_q, mem_wdata_d;

    logic [NUM_PORTS-1:0] req_any;
    logic [PTR_W-1:0]     scan_base;
    logic [PTR_W:0]       cand;
    logic                 win_found;
    logic [PTR_W-1:0]     win_idx;
    logic [PTR_W-1:0]     win_next;

    assign req_any = req_read | req_write;

`ifdef PMEM_ARB_FIXED_PRIO_EN
    assign scan_base = '0;
`else
    assign scan_base = rr_ptr_q;
`endif

    // Pick the first requesting port starting at scan_base, wrapping modulo NUM_PORTS.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            cand = {1'b0, scan_base} + (PTR_W+1)'(i);
            if (cand >= NUM_P) begin
                cand = cand - NUM_P;
            end
            if (!win_found && req_any[cand[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PTR_W-1:0];
            end
        end
    end

    assign win_next = (win_idx == LAST) ? '0 : win_idx + PTR_W'(1);

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Next state: latch the winner in IDLE, clear everything back to zero on completion.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d     = S_BUSY;
                    grant_d     = win_idx;
`ifdef PMEM_ARB_FIXED_PRIO_EN
                    rr_ptr_d    = '0;
`else
                    rr_ptr_d    = win_next;
`endif
                    mem_write_d = req_write[win_idx];
                    mem_read_d  = req_read[win_idx] & ~req_write[win_idx];
                    mem_addr_d  = req_addr[win_idx*ADDR_W +: ADDR_W];
                    mem_wdata_d = req_wdata[win_idx*LINE_W +: LINE_W];
                end
            end
            S_BUSY: begin
                if (mem_resp) begin
                    state_d     = S_IDLE;
                    grant_d     = '0;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Completion is forwarded combinationally to the granted port only.
    always_comb begin
        req_resp  = '0;
        req_rdata = '0;
        if ((state_q == S_BUSY) && mem_resp) begin
            req_resp[grant_q] = 1'b1;
            req_rdata         = mem_rdata;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q == S_BUSY);

endmodule
